// File: rtl/acc_shifter_pkg.sv
// Shared types and constants for the accumulator shifter array.
package acc_shifter_pkg;

  localparam int ACC_DATA_W     = 32;
  localparam int ACC_SRAM_DEPTH = 262144;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_REQ,
    CH_WAIT,
    CH_SHIFT
  } chan_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/acc_shifter_chan.sv
// One bit-serial channel: word fetch FSM, shift register and, with
// ACC_SHIFTER_ARRAY_PREFETCH_EN, a second word buffer for gap-free streaming.
module acc_shifter_chan
  import acc_shifter_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] img_size_i,
  input  logic              gnt_i,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              ser_o,
  output logic              ser_en_o,
  output logic              ser_start_o,
  output logic              idle_o
);

  localparam int CNT_W = (DATA_W > 1) ? clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  chan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;      // words still to be requested
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
`ifdef ACC_SHIFTER_ARRAY_PREFETCH_EN
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic              rd_pend_q, rd_pend_d; // granted last cycle, data on sram_data_i now
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    req_o   = 1'b0;
`ifdef ACC_SHIFTER_ARRAY_PREFETCH_EN
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    rd_pend_d = rd_pend_q;
`endif
    case (state_q)
      CH_IDLE: begin
        if (start_i && en_i && (img_size_i != '0)) begin
          addr_d  = start_addr_i;
          rem_d   = img_size_i;
          first_d = 1'b1;
          state_d = CH_REQ;
        end
      end
      CH_REQ: begin
        req_o = 1'b1;
        if (gnt_i) begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = CH_WAIT;
        end
      end
      CH_WAIT: begin
        sh_d    = sram_data_i;
        cnt_d   = '0;
        state_d = CH_SHIFT;
      end
      CH_SHIFT: begin
        sh_d    = sh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
`ifdef ACC_SHIFTER_ARRAY_PREFETCH_EN
        req_o = (rem_q != '0) && !buf_vld_q && !rd_pend_q;
        if (rd_pend_q) begin
          buf_d     = sram_data_i;
          buf_vld_d = 1'b1;
          rd_pend_d = 1'b0;
        end
        if (req_o && gnt_i) begin
          addr_d    = addr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          rd_pend_d = 1'b1;
        end
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (buf_vld_q) begin
            sh_d      = buf_q;
            buf_vld_d = 1'b0;
          end else if (rd_pend_q) begin
            // data lands exactly on the last bit: bypass the buffer
            sh_d      = sram_data_i;
            buf_vld_d = 1'b0;
          end else if (req_o && gnt_i) begin
            rd_pend_d = 1'b0;
            state_d   = CH_WAIT;
          end else if (rem_q != '0) begin
            state_d = CH_REQ;
          end else begin
            state_d = CH_IDLE;
          end
        end
`else
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = (rem_q != '0) ? CH_REQ : CH_IDLE;
        end
`endif
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
`ifdef ACC_SHIFTER_ARRAY_PREFETCH_EN
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      rd_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
`ifdef ACC_SHIFTER_ARRAY_PREFETCH_EN
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      rd_pend_q <= rd_pend_d;
`endif
    end
  end

  assign addr_o      = addr_q;
  assign ser_en_o    = (state_q == CH_SHIFT);
  assign ser_o       = ser_en_o & sh_q[0];
  assign ser_start_o = ser_en_o & first_q;
  assign idle_o      = (state_q == CH_IDLE);

endmodule

// File: rtl/acc_shifter_array.sv
// Bank of bit-serial accumulator shifters sharing one SRAM read port.
// Optional build macro: ACC_SHIFTER_ARRAY_PREFETCH_EN (per-channel word prefetch).
module acc_shifter_array
  import acc_shifter_pkg::*;
#(
  parameter int N_CH       = 32,
  parameter int DATA_W     = ACC_DATA_W,
  parameter int SRAM_DEPTH = ACC_SRAM_DEPTH,
  parameter int ADDR_W     = clog2(SRAM_DEPTH),
  parameter int STAGGER    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     sram_en,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [DATA_W-1:0]        sram_data,
  input  logic                     shift_start,
  output logic                     shift_start_o,
  output logic                     shift_idle,
  input  logic [N_CH-1:0]          shift_ctrl,
  input  logic [N_CH*ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]        img_size,
  output logic [N_CH-1:0]          serial_output,
  output logic [N_CH-1:0]          serial_en,
  output logic [N_CH-1:0]          serial_start
);

  localparam int DLY   = N_CH * STAGGER;
  localparam int PTR_W = (N_CH > 1) ? clog2(N_CH) : 1;

  // bit k-1 holds the start pulse delayed by k cycles
  logic [DLY-1:0] vld_pipe_q;

  logic [N_CH-1:0]             req, gnt, ch_idle;
  logic [N_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [PTR_W-1:0]            ptr_q, ptr_d, idx, gidx;
  logic                        gnt_vld;
  logic [ADDR_W-1:0]           addr_mux;

  always_ff @(posedge clk) begin
    if (!reset_n) vld_pipe_q <= '0;
    else          vld_pipe_q <= DLY'({vld_pipe_q, shift_start});
  end

  assign shift_start_o = vld_pipe_q[DLY-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    acc_shifter_chan #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (vld_pipe_q[(i+1)*STAGGER-1]),
      .en_i        (shift_ctrl[i]),
      .start_addr_i(start_addr[i*ADDR_W +: ADDR_W]),
      .img_size_i  (img_size),
      .gnt_i       (gnt[i]),
      .sram_data_i (sram_data),
      .req_o       (req[i]),
      .addr_o      (ch_addr[i]),
      .ser_o       (serial_output[i]),
      .ser_en_o    (serial_en[i]),
      .ser_start_o (serial_start[i]),
      .idle_o      (ch_idle[i])
    );
  end

  // round-robin: search starts at ptr_q, first requester wins
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gidx    = ptr_q;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N_CH);
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_vld  = 1'b1;
        gidx     = idx;
      end
    end
    ptr_d = gnt_vld ? PTR_W'((int'(gidx) + 1) % N_CH) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  always_comb begin
    addr_mux = '0;
    for (int i = 0; i < N_CH; i++)
      if (gnt[i]) addr_mux = addr_mux | ch_addr[i];
  end

  // channels are being cleared during reset, so the port stays quiet
  assign sram_en    = reset_n & gnt_vld;
  assign sram_addr  = sram_en ? addr_mux : '0;
  assign shift_idle = (&ch_idle) && (vld_pipe_q == '0);

endmodule
